// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - vectored interrupt controller with edge-detected, maskable pending sources
//
// Purpose:
//    Latches rising edges on NSRC request lines as pending bits. Applies a
//    CPU-written mask and picks the lowest-index enabled source. Presents that
//    source to the CPU through an irq/ack/eoi handshake, holding the vector
//    stable for the whole transaction.
//
// Optional feature:
//    IRQ_OVERRUN_EN - when defined, o_ovr[i] sticky-flags an edge on a source
//    whose pending bit is already set. Any mask write clears o_ovr. When the
//    macro is undefined, o_ovr is tied to zero.
//
// Ports:
//    clk       - clock
//    reset     - synchronous, active-high reset
//    i_src     - [NSRC] request lines; a rising edge is one event
//    i_we      - mask write strobe
//    i_wdata   - [NSRC] new mask value (1 = enabled)
//    i_ack     - CPU accepts the presented interrupt
//    i_eoi     - CPU end-of-interrupt
//    o_irq     - interrupt request to the CPU
//    o_vector  - [VEC_W] index of the presented or serviced source
//    o_busy    - handler in progress
//    o_pending - [NSRC] latched pending bits, before masking
//    o_mask    - [NSRC] current mask register
//    o_ovr     - [NSRC] overrun flags
module irq_ctrl #(
   parameter int NSRC  = 4,
   parameter int VEC_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NSRC-1:0]  i_src,
   input  logic             i_we,
   input  logic [NSRC-1:0]  i_wdata,
   input  logic             i_ack,
   input  logic             i_eoi,
   output logic             o_irq,
   output logic [VEC_W-1:0] o_vector,
   output logic             o_busy,
   output logic [NSRC-1:0]  o_pending,
   output logic [NSRC-1:0]  o_mask,
   output logic [NSRC-1:0]  o_ovr
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      SERV = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [NSRC-1:0]   r_src_d;
   logic [NSRC-1:0]   r_pending;
   logic [NSRC-1:0]   r_mask;
   logic [VEC_W-1:0]  r_vector;

   logic [NSRC-1:0]   w_edge;
   logic [NSRC-1:0]   w_eligible;
   logic [NSRC-1:0]   w_mask_nxt;
   logic [NSRC-1:0]   w_clr;
   logic [VEC_W-1:0]  w_prio;
   logic              w_ack_fire;
   logic              w_load_vec;

   assign w_edge     = i_src & ~r_src_d;
   assign w_eligible = r_pending & r_mask;
   // Mask as it will be after this edge; lets a same-cycle write withdraw a request.
   assign w_mask_nxt = i_we ? i_wdata : r_mask;
   assign w_ack_fire = (r_state == REQ) && i_ack;

   // Lowest index wins: scan downwards so the last hit is the smallest index.
   always_comb begin
      w_prio = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (w_eligible[i]) begin
            w_prio = VEC_W'(i);
         end
      end
   end

   always_comb begin
      w_clr = '0;
      if (w_ack_fire) begin
         w_clr[r_vector] = 1'b1;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and state-decoded outputs
   always_comb begin
      w_state_nxt = r_state;
      w_load_vec  = 1'b0;
      o_irq       = 1'b0;
      o_busy      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_eligible != '0) begin
               w_load_vec  = 1'b1;
               w_state_nxt = REQ;
            end
         end
         REQ: begin
            o_irq = 1'b1;
            // ack beats a same-cycle mask write that would withdraw the request
            if (i_ack) begin
               w_state_nxt = SERV;
            end else if (!w_mask_nxt[r_vector]) begin
               w_state_nxt = IDLE;
            end
         end
         SERV: begin
            o_busy = 1'b1;
            if (i_eoi) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      // src_d tracks src even in reset so a line high across reset release is not an event
      r_src_d <= i_src;
      if (reset) begin
         r_pending <= '0;
         r_mask    <= '0;
         r_vector  <= '0;
      end else begin
         // A new edge wins over an ack clear on the same bit
         r_pending <= (r_pending & ~w_clr) | w_edge;
         r_mask    <= w_mask_nxt;
         if (w_load_vec) begin
            r_vector <= w_prio;
         end
      end
   end

`ifdef IRQ_OVERRUN_EN
   logic [NSRC-1:0] r_ovr;
   logic [NSRC-1:0] w_ovr_set;

   // Overrun only when the earlier event is still outstanding after this edge's ack
   assign w_ovr_set = w_edge & r_pending & ~w_clr;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ovr <= '0;
      end else begin
         r_ovr <= (i_we ? '0 : r_ovr) | w_ovr_set;
      end
   end

   assign o_ovr = r_ovr;
`else
   assign o_ovr = '0;
`endif

   assign o_vector  = r_vector;
   assign o_pending = r_pending;
   assign o_mask    = r_mask;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - directed self-checking bench for irq_ctrl
module tb_irq_ctrl;

   localparam int NSRC  = 4;
   localparam int VEC_W = 2;

`ifdef IRQ_OVERRUN_EN
   localparam logic [3:0] EXP_OVR = 4'b0100;
`else
   localparam logic [3:0] EXP_OVR = 4'b0000;
`endif

   logic             clk;
   logic             reset;
   logic [NSRC-1:0]  i_src;
   logic             i_we;
   logic [NSRC-1:0]  i_wdata;
   logic             i_ack;
   logic             i_eoi;
   logic             o_irq;
   logic [VEC_W-1:0] o_vector;
   logic             o_busy;
   logic [NSRC-1:0]  o_pending;
   logic [NSRC-1:0]  o_mask;
   logic [NSRC-1:0]  o_ovr;

   int n_checks;
   int n_errors;

   irq_ctrl #(
      .NSRC  (NSRC),
      .VEC_W (VEC_W)
   ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .i_src     (i_src),
      .i_we      (i_we),
      .i_wdata   (i_wdata),
      .i_ack     (i_ack),
      .i_eoi     (i_eoi),
      .o_irq     (o_irq),
      .o_vector  (o_vector),
      .o_busy    (o_busy),
      .o_pending (o_pending),
      .o_mask    (o_mask),
      .o_ovr     (o_ovr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_mask(input logic [3:0] m);
      i_we    = 1'b1;
      i_wdata = m;
      tick();
      i_we    = 1'b0;
      i_wdata = '0;
   endtask

   task automatic pulse(input logic [3:0] s);
      i_src = s;
      tick();
      i_src = '0;
   endtask

   task automatic do_ack();
      i_ack = 1'b1;
      tick();
      i_ack = 1'b0;
   endtask

   task automatic do_eoi();
      i_eoi = 1'b1;
      tick();
      i_eoi = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset    = 1'b1;
      i_src    = '0;
      i_we     = 1'b0;
      i_wdata  = '0;
      i_ack    = 1'b0;
      i_eoi    = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      check("rst_irq", o_irq, 0);
      check("rst_vector", o_vector, 0);
      check("rst_busy", o_busy, 0);
      check("rst_pending", o_pending, 0);
      check("rst_mask", o_mask, 0);
      check("rst_ovr", o_ovr, 0);

      // Basic request/ack/eoi on source 0
      write_mask(4'b0001);
      check("t1_mask", o_mask, 4'b0001);
      pulse(4'b0001);
      check("t1_pending", o_pending, 4'b0001);
      check("t1_irq_early", o_irq, 0);
      tick();
      check("t1_irq", o_irq, 1);
      check("t1_vector", o_vector, 0);
      do_ack();
      check("t1_ack_irq", o_irq, 0);
      check("t1_ack_busy", o_busy, 1);
      check("t1_ack_pending", o_pending, 4'b0000);
      do_eoi();
      check("t1_eoi_busy", o_busy, 0);

      // Priority and vector freezing
      write_mask(4'b1111);
      pulse(4'b0110);
      check("t2_pending", o_pending, 4'b0110);
      tick();
      check("t2_irq", o_irq, 1);
      check("t2_vector", o_vector, 1);
      pulse(4'b0001);
      check("t2_frozen_vector", o_vector, 1);
      check("t2_frozen_pending", o_pending, 4'b0111);
      do_ack();
      check("t2_ack_pending", o_pending, 4'b0101);
      do_eoi();
      check("t2_gap_irq", o_irq, 0);
      tick();
      check("t2_next_irq", o_irq, 1);
      check("t2_next_vector", o_vector, 0);
      do_ack();
      do_eoi();
      tick();
      check("t2_last_irq", o_irq, 1);
      check("t2_last_vector", o_vector, 2);
      do_ack();
      do_eoi();
      check("t2_drained", o_pending, 4'b0000);

      // Masked retention
      write_mask(4'b0000);
      pulse(4'b1000);
      check("t3_pending", o_pending, 4'b1000);
      tick();
      tick();
      check("t3_masked_irq", o_irq, 0);
      write_mask(4'b1000);
      check("t3_unmask_irq_early", o_irq, 0);
      tick();
      check("t3_unmask_irq", o_irq, 1);
      check("t3_vector", o_vector, 3);
      do_ack();
      do_eoi();

      // Withdraw by masking before ack
      write_mask(4'b0010);
      pulse(4'b0010);
      tick();
      check("t4_irq", o_irq, 1);
      check("t4_vector", o_vector, 1);
      write_mask(4'b0000);
      check("t4_withdraw_irq", o_irq, 0);
      check("t4_withdraw_pending", o_pending, 4'b0010);
      check("t4_withdraw_busy", o_busy, 0);
      write_mask(4'b0010);
      tick();
      check("t4_rerequest", o_irq, 1);
      do_ack();
      do_eoi();

      // Level held high counts once
      write_mask(4'b0001);
      i_src = 4'b0001;
      for (int i = 0; i < 10; i++) tick();
      check("t5_level_irq", o_irq, 1);
      check("t5_level_vector", o_vector, 0);
      i_src = '0;
      tick();
      do_ack();
      check("t5_level_cleared", o_pending, 4'b0000);
      do_eoi();
      tick();
      tick();
      check("t5_single_event_irq", o_irq, 0);
      check("t5_single_event_pending", o_pending, 4'b0000);

      // Edge coinciding with ack keeps the bit pending
      pulse(4'b0001);
      tick();
      check("t6_irq", o_irq, 1);
      i_src = 4'b0001;
      i_ack = 1'b1;
      tick();
      i_src = '0;
      i_ack = 1'b0;
      check("t6_set_wins", o_pending, 4'b0001);
      check("t6_busy", o_busy, 1);
      do_eoi();
      tick();
      check("t6_rerequest_irq", o_irq, 1);
      check("t6_rerequest_vector", o_vector, 0);

      // Spurious eoi in REQ, spurious ack in IDLE
      do_eoi();
      check("t7_eoi_in_req_irq", o_irq, 1);
      check("t7_eoi_in_req_busy", o_busy, 0);
      do_ack();
      do_eoi();
      do_ack();
      check("t7_ack_in_idle_irq", o_irq, 0);
      check("t7_ack_in_idle_busy", o_busy, 0);
      check("t7_ack_in_idle_pending", o_pending, 4'b0000);

      // Overrun
      write_mask(4'b0000);
      pulse(4'b0100);
      tick();
      pulse(4'b0100);
      check("t8_ovr_set", o_ovr, EXP_OVR);
      tick();
      check("t8_ovr_sticky", o_ovr, EXP_OVR);
      write_mask(4'b0000);
      check("t8_ovr_cleared", o_ovr, 4'b0000);
      check("t8_pending_kept", o_pending, 4'b0100);

      // Reset while servicing
      write_mask(4'b0100);
      tick();
      check("t9_irq", o_irq, 1);
      check("t9_vector", o_vector, 2);
      do_ack();
      check("t9_busy", o_busy, 1);
      pulse(4'b0001);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t9_rst_irq", o_irq, 0);
      check("t9_rst_vector", o_vector, 0);
      check("t9_rst_busy", o_busy, 0);
      check("t9_rst_pending", o_pending, 0);
      check("t9_rst_mask", o_mask, 0);
      check("t9_rst_ovr", o_ovr, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
